// File: rtl/ex_branch_unit_pkg.sv
// Shared decode constants for the EX-stage branch resolver: opcodes, IR field positions, defaults.
// The optional statistics counters are enabled by defining BRANCH_STATS_EN.
package ex_branch_unit_pkg;

    localparam int PC_W_DEF         = 10;
    localparam int SQUASH_DEPTH_DEF = 3;
    localparam int STAT_W_DEF       = 16;

    // Opcode field of the instruction word
    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;

    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_BEQ  = 5'd16;
    localparam logic [4:0] OP_BGT  = 5'd17;
    localparam logic [4:0] OP_B    = 5'd18;
    localparam logic [4:0] OP_CALL = 5'd19;
    localparam logic [4:0] OP_RET  = 5'd20;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_KILL = 1'b1
    } squash_state_t;

    function automatic logic [4:0] ir_opcode(input logic [31:0] ir);
        return ir[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/ex_branch_unit_if.sv
// OF/EX-side bundle of the branch resolver: latch contents in, redirect/flags/status out.
// The master is the pipeline around EX; the slave is ex_branch_unit.
interface ex_branch_unit_if #(
    parameter int PC_W   = 10,
    parameter int STAT_W = 16
);
    logic              ex_stall;
    logic              in_valid;
    logic [PC_W-1:0]   input_EX_PC;
    logic [31:0]       input_EX_IR;
    logic [31:0]       EX_branchTarget;
    logic [31:0]       Operand_EX_A;
    logic [31:0]       Operand_EX_2;

    logic              is_Branch_Taken;
    logic [PC_W-1:0]   branchPC;
    logic              flag_E;
    logic              flag_GT;
    logic              ex_valid;
    logic [31:0]       ret_addr;
    logic [STAT_W-1:0] stat_resolved;
    logic [STAT_W-1:0] stat_taken;
    logic [STAT_W-1:0] stat_squashed;

    modport master (
        output ex_stall, in_valid, input_EX_PC, input_EX_IR,
               EX_branchTarget, Operand_EX_A, Operand_EX_2,
        input  is_Branch_Taken, branchPC, flag_E, flag_GT, ex_valid, ret_addr,
               stat_resolved, stat_taken, stat_squashed
    );

    modport slave (
        input  ex_stall, in_valid, input_EX_PC, input_EX_IR,
               EX_branchTarget, Operand_EX_A, Operand_EX_2,
        output is_Branch_Taken, branchPC, flag_E, flag_GT, ex_valid, ret_addr,
               stat_resolved, stat_taken, stat_squashed
    );

endinterface

// File: rtl/ex_branch_unit_squash_fsm.sv
// Wrong-path squash sequencer: after a taken redirect, kills SQUASH_DEPTH unstalled EX slots.
// Bubbles consume slots too; a stalled cycle holds the remaining count.
module ex_squash_fsm
    import ex_branch_unit_pkg::*;
#(
    parameter int SQUASH_DEPTH = SQUASH_DEPTH_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_taken,
    input  logic i_ex_stall,
    output logic o_squashing,
    output logic o_kill_step
);

    localparam int CNT_W = $clog2(SQUASH_DEPTH + 1);

    squash_state_t    r_state;
    logic [CNT_W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_taken) begin
                        r_state <= ST_KILL;
                        r_cnt   <= CNT_W'(SQUASH_DEPTH);
                    end
                end
                ST_KILL: begin
                    if (!i_ex_stall) begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_squashing = (r_state == ST_KILL);
    assign o_kill_step = o_squashing & ~i_ex_stall;

endmodule

// File: rtl/ex_branch_unit.sv
// EX-stage branch resolver: flags, registered one-cycle redirect to IF, wrong-path squash.
// Define BRANCH_STATS_EN to build the resolved/taken/squashed statistics counters.
module ex_branch_unit
    import ex_branch_unit_pkg::*;
#(
    parameter int PC_W         = PC_W_DEF,
    parameter int SQUASH_DEPTH = SQUASH_DEPTH_DEF,
    parameter int STAT_W       = STAT_W_DEF
) (
    input logic            clk,
    input logic            reset,
    ex_branch_unit_if.slave bus
);

    logic [4:0]      w_opcode;
    logic            w_squashing;
    logic            w_kill_step;
    logic            w_live;
    logic            w_is_cmp, w_is_beq, w_is_bgt, w_is_b, w_is_call, w_is_ret;
    logic            w_is_cf;
    logic            w_taken;
    logic [PC_W-1:0] w_target;
    logic            w_unused;

    logic            r_taken;
    logic [PC_W-1:0] r_branch_pc;
    logic            r_flag_e;
    logic            r_flag_gt;

    assign w_opcode  = ir_opcode(bus.input_EX_IR);
    assign w_is_cmp  = (w_opcode == OP_CMP);
    assign w_is_beq  = (w_opcode == OP_BEQ);
    assign w_is_bgt  = (w_opcode == OP_BGT);
    assign w_is_b    = (w_opcode == OP_B);
    assign w_is_call = (w_opcode == OP_CALL);
    assign w_is_ret  = (w_opcode == OP_RET);
    assign w_is_cf   = w_is_beq | w_is_bgt | w_is_b | w_is_call | w_is_ret;

    assign w_live  = bus.in_valid & ~w_squashing & ~bus.ex_stall;
    // Conditional branches read the flags register directly; a preceding cmp has already written it.
    assign w_taken = w_live & (w_is_b | w_is_call | w_is_ret |
                               (w_is_beq & r_flag_e) | (w_is_bgt & r_flag_gt));
    assign w_target = w_is_ret ? bus.Operand_EX_A[PC_W-1:0] : bus.EX_branchTarget[PC_W-1:0];

    ex_squash_fsm #(
        .SQUASH_DEPTH (SQUASH_DEPTH)
    ) u_squash_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_taken     (w_taken),
        .i_ex_stall  (bus.ex_stall),
        .o_squashing (w_squashing),
        .o_kill_step (w_kill_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_taken     <= 1'b0;
            r_branch_pc <= '0;
            r_flag_e    <= 1'b0;
            r_flag_gt   <= 1'b0;
        end else begin
            r_taken <= w_taken;
            if (w_taken) begin
                r_branch_pc <= w_target;
            end
            if (w_live && w_is_cmp) begin
                r_flag_e  <= (bus.Operand_EX_A == bus.Operand_EX_2);
                r_flag_gt <= ($signed(bus.Operand_EX_A) > $signed(bus.Operand_EX_2));
            end
        end
    end

    assign bus.is_Branch_Taken = r_taken;
    assign bus.branchPC        = r_branch_pc;
    assign bus.flag_E          = r_flag_e;
    assign bus.flag_GT         = r_flag_gt;
    assign bus.ex_valid        = bus.in_valid & ~w_squashing;
    assign bus.ret_addr        = 32'(bus.input_EX_PC) + 32'd4;

`ifdef BRANCH_STATS_EN
    logic [STAT_W-1:0] r_stat_resolved;
    logic [STAT_W-1:0] r_stat_taken;
    logic [STAT_W-1:0] r_stat_squashed;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_resolved <= '0;
            r_stat_taken    <= '0;
            r_stat_squashed <= '0;
        end else begin
            if (w_live && w_is_cf) r_stat_resolved <= r_stat_resolved + 1'b1;
            if (w_taken)           r_stat_taken    <= r_stat_taken + 1'b1;
            if (w_kill_step)       r_stat_squashed <= r_stat_squashed + 1'b1;
        end
    end

    assign bus.stat_resolved = r_stat_resolved;
    assign bus.stat_taken    = r_stat_taken;
    assign bus.stat_squashed = r_stat_squashed;
`else
    assign bus.stat_resolved = '0;
    assign bus.stat_taken    = '0;
    assign bus.stat_squashed = '0;
`endif

    // Low IR bits and high target bits are decoded elsewhere in the pipeline.
    assign w_unused = ^{bus.input_EX_IR[OPC_LSB-1:0], bus.EX_branchTarget[31:PC_W],
                        w_kill_step, w_is_cf};

endmodule

// File: tb/tb_ex_branch_unit.sv
// Self-checking bench for ex_branch_unit: directed branch scenarios plus random traffic
// checked cycle by cycle against a slot-counting reference model.
module tb_ex_branch_unit;

    localparam int PC_W   = 10;
    localparam int STAT_W = 16;

    localparam logic [4:0] C_CMP  = 5'd5;
    localparam logic [4:0] C_BEQ  = 5'd16;
    localparam logic [4:0] C_BGT  = 5'd17;
    localparam logic [4:0] C_B    = 5'd18;
    localparam logic [4:0] C_CALL = 5'd19;
    localparam logic [4:0] C_RET  = 5'd20;
    localparam logic [4:0] C_ADD  = 5'd0;

    logic clk = 1'b0;
    logic reset;

    ex_branch_unit_if #(.PC_W(PC_W), .STAT_W(STAT_W)) bus ();

    ex_branch_unit #(.PC_W(PC_W), .SQUASH_DEPTH(3), .STAT_W(STAT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: architectural view of the unit
    bit          m_fe, m_fgt;
    int          m_slots_left;    // wrong-path slots still to be killed
    bit          m_redirect;      // redirect visible this cycle
    int unsigned m_bpc;
    int unsigned m_resolved, m_taken_cnt, m_squashed;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fe = 0; m_fgt = 0; m_slots_left = 0; m_redirect = 0; m_bpc = 0;
        m_resolved = 0; m_taken_cnt = 0; m_squashed = 0;
    endtask

    // Drive one cycle of EX inputs, check outputs mid-cycle, then advance the model across the edge.
    task automatic step(input bit v, input bit st, input logic [4:0] opc, input int unsigned pc,
                        input logic [31:0] tgt, input logic [31:0] a, input logic [31:0] b2);
        bit          live, take;
        int unsigned tpc;
        bus.in_valid        = v;
        bus.ex_stall        = st;
        bus.input_EX_IR     = {opc, 27'($urandom)};
        bus.input_EX_PC     = pc[PC_W-1:0];
        bus.EX_branchTarget = tgt;
        bus.Operand_EX_A    = a;
        bus.Operand_EX_2    = b2;
        @(negedge clk);
        check("ex_valid", bus.ex_valid, 32'(v && m_slots_left == 0));
        check("is_Branch_Taken", bus.is_Branch_Taken, 32'(m_redirect));
        check("branchPC", bus.branchPC, m_bpc);
        check("flag_E", bus.flag_E, 32'(m_fe));
        check("flag_GT", bus.flag_GT, 32'(m_fgt));
        check("ret_addr", bus.ret_addr, pc + 4);
`ifdef BRANCH_STATS_EN
        check("stat_resolved", bus.stat_resolved, m_resolved % 65536);
        check("stat_taken", bus.stat_taken, m_taken_cnt % 65536);
        check("stat_squashed", bus.stat_squashed, m_squashed % 65536);
`else
        check("stat_resolved", bus.stat_resolved, 0);
        check("stat_taken", bus.stat_taken, 0);
        check("stat_squashed", bus.stat_squashed, 0);
`endif
        live = v && !st && m_slots_left == 0;
        take = live && (opc == C_B || opc == C_CALL || opc == C_RET ||
                        (opc == C_BEQ && m_fe) || (opc == C_BGT && m_fgt));
        tpc  = (opc == C_RET) ? (a % 1024) : (tgt % 1024);
        if (live && (opc inside {C_BEQ, C_BGT, C_B, C_CALL, C_RET})) m_resolved++;
        if (m_slots_left > 0 && !st) begin
            m_slots_left--;
            m_squashed++;
        end
        if (take) begin
            m_slots_left = 3;
            m_bpc = tpc;
            m_taken_cnt++;
        end
        m_redirect = take;
        if (live && opc == C_CMP) begin
            m_fe  = (a == b2);
            m_fgt = ($signed(a) > $signed(b2));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input bit st);
        step(1'b1, st, C_ADD, 10'h100, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        bus.in_valid = 0; bus.ex_stall = 0; bus.input_EX_IR = 0; bus.input_EX_PC = 0;
        bus.EX_branchTarget = 0; bus.Operand_EX_A = 0; bus.Operand_EX_2 = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Live b: one-cycle redirect, three killed slots, fourth slot live
        step(1, 0, C_B, 10'h010, 32'h040, 0, 0);
        check("b_redirect_now", bus.is_Branch_Taken, 1);
        check("b_target_now", bus.branchPC, 32'h040);
        nop(0); nop(0); nop(0); nop(0);

        // cmp equal then beq taken; cmp unequal then beq not taken
        step(1, 0, C_CMP, 10'h050, 0, 32'd5, 32'd5);
        step(1, 0, C_BEQ, 10'h054, 32'h080, 0, 0);
        nop(0); nop(0); nop(0); nop(0);
        step(1, 0, C_CMP, 10'h060, 0, 32'd5, 32'd7);
        step(1, 0, C_BEQ, 10'h064, 32'h080, 0, 0);
        nop(0); nop(0);

        // Signed compare feeding bgt
        step(1, 0, C_CMP, 10'h070, 0, 32'hFFFF_FFFF, 32'd1);
        step(1, 0, C_BGT, 10'h074, 32'h0C0, 0, 0);
        nop(0);
        step(1, 0, C_CMP, 10'h078, 0, 32'd3, 32'hFFFF_FFFE);
        step(1, 0, C_BGT, 10'h07C, 32'h0C0, 0, 0);
        nop(0); nop(0); nop(0); nop(0);

        // ret through ra, call with return address
        step(1, 0, C_RET, 10'h090, 32'h3FF, 32'h1F4, 0);
        nop(0); nop(0); nop(0); nop(0);
        step(1, 0, C_CALL, 10'h020, 32'h200, 0, 0);
        nop(0); nop(0); nop(0); nop(0);

        // Stall inside KILL, with a b landing in a squashed slot
        step(1, 0, C_B, 10'h030, 32'h140, 0, 0);
        nop(0); nop(1); nop(1);
        step(1, 0, C_B, 10'h034, 32'h1C0, 0, 0);
        step(0, 0, C_ADD, 10'h038, 0, 0, 0);
        nop(0); nop(0);

        // Reset while in KILL with two slots left
        step(1, 0, C_CMP, 10'h0A0, 0, 32'd9, 32'd2);
        step(1, 0, C_B, 10'h0A4, 32'h2A0, 0, 0);
        nop(0);
        reset = 1'b1;
        bus.in_valid = 1; bus.input_EX_IR = {C_B, 27'd0};
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        nop(0);
        step(0, 0, C_ADD, 10'h0B0, 0, 0, 0);
        nop(0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [4:0]  opc;
            logic [31:0] a, b2;
            int          sel;
            sel = $urandom_range(0, 7);
            case (sel)
                0: opc = C_CMP;  1: opc = C_BEQ;  2: opc = C_BGT;
                3: opc = C_B;    4: opc = C_CALL; 5: opc = C_RET;
                6: opc = C_CMP;
                default: opc = 5'($urandom_range(21, 31));
            endcase
            if ($urandom_range(0, 3) == 0) begin
                a  = $urandom;
                b2 = $urandom;
            end else begin
                a  = 32'($signed($urandom_range(0, 6)) - 3);
                b2 = 32'($signed($urandom_range(0, 6)) - 3);
            end
            step($urandom_range(0, 9) < 8, $urandom_range(0, 4) == 0, opc,
                 $urandom_range(0, 10'h3EF), $urandom, a, b2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ex_branch_unit.md
Name: ex_branch_unit

Overview:
- Execute-stage branch resolver; sits on the EX side of the OF/EX latch.
- Closes the loop back to the IF stage by driving is_Branch_Taken and branchPC.
- Owns the flags register, written by cmp.
- Owns the wrong-path squash sequencing required by predict-not-taken, no delayed branches.
- Emits ex_valid so later stages drop squashed instructions.

Parameters:
- PC_W, 10, width of PC / branchPC.
- SQUASH_DEPTH, 3, wrong-path slots killed after a taken redirect (IF samples the registered redirect one cycle late).
- STAT_W, 16, width of statistics counters (optional feature only).

Ports:
- clk  input  1  single clock, all state on posedge.
- reset  input  1  synchronous, active-high.
- ex_stall  input  1  EX held this cycle (latch contents unchanged).
- in_valid  input  1  OF/EX latch holds a real instruction (0 = interlock bubble).
- input_EX_PC  input  PC_W  PC of instruction in EX.
- input_EX_IR  input  32  instruction in EX; opcode IR[31:27].
- EX_branchTarget  input  32  PC-relative target computed in OF.
- Operand_EX_A  input  32  rs1 value, or ra for ret.
- Operand_EX_2  input  32  second ALU operand (rs2 or immediate, already muxed).
- is_Branch_Taken  output  1  one-cycle redirect pulse to IF.
- branchPC  output  PC_W  redirect target, valid while is_Branch_Taken=1.
- flag_E  output  1  equality flag.
- flag_GT  output  1  signed greater-than flag.
- ex_valid  output  1  instruction in EX is live (in_valid and not squashed).
- ret_addr  output  32  zero-extended input_EX_PC+4, for call writeback of ra.
- stat_resolved  output  STAT_W  control-flow instructions resolved.
- stat_taken  output  STAT_W  redirects issued.
- stat_squashed  output  STAT_W  slots killed.

Behaviour:
- Opcodes: cmp=5, beq=16, bgt=17, b=18, call=19, ret=20; all others are non-branch.
- live = in_valid & ~squashing & ~ex_stall; ex_valid = in_valid & ~squashing, combinational.
- Flags: on live cmp, flag_E <= (A == Operand_EX_2) and flag_GT <= ($signed(A) > $signed(Operand_EX_2)) at the posedge. The following beq/bgt sees the updated flags; no forwarding path is needed. Flags are otherwise held. Reset clears both.
- Taken condition: b | call | ret | (beq & flag_E) | (bgt & flag_GT), qualified by live.
- Target: ret uses Operand_EX_A[PC_W-1:0]; the others use EX_branchTarget[PC_W-1:0].
- Redirect is registered: taken in cycle T gives is_Branch_Taken=1 and branchPC=target during T+1 only. It is never stretched by ex_stall.
- branchPC holds its last value when not taken. Reset value is 0.
- Squash FSM states:
  - RUN: on taken, go to KILL and load cnt = SQUASH_DEPTH.
  - KILL: squashing=1; cnt decrements on every cycle with ex_stall=0, whether or not in_valid (bubbles consume slots); on cnt=1 & ~ex_stall, return to RUN.
  - ex_stall in KILL holds cnt.
- A branch arriving in EX during KILL is squashed: no flags update, no redirect.
- Untaken beq/bgt: no redirect, no squash; the fall-through is already correct.
- Reset in any state: RUN, cnt=0, is_Branch_Taken=0, branchPC=0, flags=0, stats=0.
- ret_addr is combinational and meaningful only for call.

Optional Feature:
- Macro BRANCH_STATS_EN.
- Defined: stat_resolved increments on live beq/bgt/b/call/ret; stat_taken increments on each redirect; stat_squashed increments on each decrementing KILL cycle. All three wrap modulo 2^STAT_W.
- Undefined: the three ports are tied to 0 and no counter flops are inferred.

Decomposition:
- Shared package/include file: opcode localparams (matching the EX/control decode), IR field bit positions, PC_W default.
- One natural sub-module: ex_squash_fsm (RUN/KILL state, cnt, squashing output), instantiated once.
- Flags, redirect registers and stats stay in the top module.

Test Plan:
- Live b at PC=0x010, target 0x040 → next cycle is_Branch_Taken=1, branchPC=0x040 for exactly one cycle; the next 3 slots have ex_valid=0; the 4th slot is live.
- cmp A=5, B=5 then beq (target 0x080) → flag_E=1, flag_GT=0, redirect to 0x080. Repeat with A=5, B=7 → flag_E=0, no redirect, no squash.
- cmp A=-1, B=1 then bgt → flag_GT=0 (signed compare), not taken. cmp A=3, B=-2 then bgt → taken.
- ret with Operand_EX_A=0x1F4 → branchPC=0x1F4. call at PC=0x020 → ret_addr=0x024, plus redirect.
- Taken b, then ex_stall=1 for 2 cycles during KILL → redirect pulse still one cycle; squash spans 3 unstalled cycles; a b arriving in a squashed slot produces no redirect.
- Assert reset in KILL with cnt=2 → next cycle RUN, ex_valid follows in_valid, flags/branchPC/stats = 0. With BRANCH_STATS_EN defined, the scenarios above yield the expected stat counts.
